// File: rtl/memory_loader_pkg.sv
// rtl/memory_loader_pkg.sv - shared widths and FSM state type for the memory loader
package memory_loader_pkg;

    // Memory word width and number of significant word-address bits
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 11;

    // Width of the memory data-port address bus driven by the loader
    localparam int PORT_ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/memory_loader.sv
// rtl/memory_loader.sv - streams words into memory, reads them back and compares sums
module memory_loader #(
    parameter int DATA_W = memory_loader_pkg::DATA_W,
    parameter int ADDR_W = memory_loader_pkg::ADDR_W
) (
    input  logic                iclk,
    input  logic                irst_n,
    input  logic                iStart,
    input  logic [ADDR_W-1:0]   iBase,
    input  logic [ADDR_W:0]     iLen,
    input  logic                iValid,
    input  logic [DATA_W-1:0]   iWord,
    output logic                oReady,
    output logic [15:0]         oDataAddr,
    output logic [DATA_W-1:0]   oData,
    output logic                oDataWrite,
    input  logic [DATA_W-1:0]   iMemData,
    output logic                oBusy,
    output logic                oDone,
    output logic                oErr,
    output logic [DATA_W-1:0]   oChecksum
);

    import memory_loader_pkg::*;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_count;
    logic [DATA_W-1:0]   r_wsum;
    logic [DATA_W-1:0]   r_rsum;

    logic                w_start_ok;
    logic                w_xfer;
    logic                w_last;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_rsum_next;

    // A start is only honoured when no load is in flight
    assign w_start_ok  = iStart && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    assign w_xfer      = (r_state == LOAD) && iValid;
    assign w_last      = (r_count == (r_len - CNT_ONE));
    // Address arithmetic is ADDR_W wide so it wraps naturally at the top of memory
    assign w_addr      = r_base + r_count[ADDR_W-1:0];
    assign w_rsum_next = r_rsum + iMemData;

    // Memory port is driven straight from the current cycle so a write lands with its word
    assign oDataWrite  = w_xfer;
    assign oData       = w_xfer ? iWord : '0;
    assign oDataAddr   = ((r_state == LOAD) || (r_state == CHECK))
                         ? {{(16-ADDR_W){1'b0}}, w_addr} : '0;
    assign oChecksum   = r_wsum;

    // State register
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state status outputs
    always_comb begin
        w_next = r_state;
        oReady = 1'b0;
        oBusy  = 1'b0;
        oDone  = 1'b0;
        oErr   = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                oDone = (r_state == DONE);
                oErr  = (r_state == ERR);
                if (iStart) begin
                    w_next = (iLen == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                oReady = 1'b1;
                oBusy  = 1'b1;
                if (iValid && w_last) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                oBusy = 1'b1;
                // The final readback word is folded in before the comparison
                if (w_last) begin
                    w_next = (w_rsum_next == r_wsum) ? DONE : ERR;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Load parameters, word counter and the write/read running sums
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_base  <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_wsum  <= '0;
            r_rsum  <= '0;
        end else if (w_start_ok) begin
            r_base  <= iBase;
            r_len   <= iLen;
            r_count <= '0;
            r_wsum  <= '0;
            r_rsum  <= '0;
        end else if (w_xfer) begin
            r_wsum  <= r_wsum + iWord;
            r_count <= w_last ? '0 : (r_count + CNT_ONE);
        end else if (r_state == CHECK) begin
            r_rsum  <= w_rsum_next;
            r_count <= w_last ? '0 : (r_count + CNT_ONE);
        end
    end

endmodule

// File: tb/tb_memory_loader.sv
// tb/tb_memory_loader.sv - randomized scoreboard bench for memory_loader
module tb_memory_loader;

    localparam int DW = 16;
    localparam int AW = 11;

    logic           iclk;
    logic           irst_n;
    logic           iStart;
    logic [AW-1:0]  iBase;
    logic [AW:0]    iLen;
    logic           iValid;
    logic [DW-1:0]  iWord;
    logic           oReady;
    logic [15:0]    oDataAddr;
    logic [DW-1:0]  oData;
    logic           oDataWrite;
    logic [DW-1:0]  iMemData;
    logic           oBusy;
    logic           oDone;
    logic           oErr;
    logic [DW-1:0]  oChecksum;

    memory_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .iStart     (iStart),
        .iBase      (iBase),
        .iLen       (iLen),
        .iValid     (iValid),
        .iWord      (iWord),
        .oReady     (oReady),
        .oDataAddr  (oDataAddr),
        .oData      (oData),
        .oDataWrite (oDataWrite),
        .iMemData   (iMemData),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oErr       (oErr),
        .oChecksum  (oChecksum)
    );

    typedef struct {
        logic [15:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    bit            corrupt = 0;
    logic [DW-1:0] mem [0:2047];

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc <= cyc + 1;

    // Memory model; optionally damages the word stored at 0x011
    always @(posedge iclk) begin
        if (oDataWrite) begin
            if (corrupt && oDataAddr == 16'h0011)
                mem[oDataAddr[AW-1:0]] <= oData ^ 16'h0001;
            else
                mem[oDataAddr[AW-1:0]] <= oData;
        end
    end
    assign iMemData = mem[oDataAddr[AW-1:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every memory write must match the next expected write
    always @(negedge iclk) begin
        if (irst_n && oDataWrite) begin
            check("write_only_when_valid", {31'd0, iValid}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {16'd0, oDataAddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", {16'd0, oDataAddr}, {16'd0, e.addr});
                check("write_data", {16'd0, oData}, {16'd0, e.data});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  {16'd0, oDataAddr}, 32'd0);
        check({tag, "_data"},  {16'd0, oData},     32'd0);
        check({tag, "_wr"},    {31'd0, oDataWrite}, 32'd0);
        check({tag, "_ready"}, {31'd0, oReady},    32'd0);
        check({tag, "_busy"},  {31'd0, oBusy},     32'd0);
        check({tag, "_done"},  {31'd0, oDone},     32'd0);
        check({tag, "_err"},   {31'd0, oErr},      32'd0);
        check({tag, "_csum"},  {16'd0, oChecksum}, 32'd0);
    endtask

    // valid_pct: percentage chance of iValid per cycle; negative means strict 1,0,1,0 toggling
    task automatic do_load(input int base, input int len, input int valid_pct,
                           input bit fixed_words, input bit restart_mid);
        logic [DW-1:0] words[$];
        logic [DW-1:0] sum;
        bit            exp_err;
        bit            x;
        int            t0, idx, guard, lat;
        sum     = '0;
        exp_err = 0;
        for (int i = 0; i < len; i++) begin
            logic [DW-1:0] w;
            wr_t           e;
            w = fixed_words ? DW'(i + 1) : DW'($urandom);
            words.push_back(w);
            e.addr = 16'((base + i) % 2048);
            e.data = w;
            exp_q.push_back(e);
            sum = sum + w;
            if (corrupt && e.addr == 16'h0011) exp_err = 1;
        end
        @(posedge iclk); #1;
        iStart = 1'b1;
        iBase  = AW'(base);
        iLen   = (AW + 1)'(len);
        t0     = cyc;
        @(posedge iclk); #1;
        iStart = 1'b0;
        idx    = 0;
        guard  = 0;
        while (idx < len && guard < 20 * len + 100) begin
            if (valid_pct < 0) iValid = (guard % 2 == 0);
            else               iValid = ($urandom_range(99) < valid_pct);
            iWord = words[idx];
            if (restart_mid && guard == 1) begin
                iStart = 1'b1;
                iBase  = AW'($urandom);
                iLen   = 12'd5;
            end else begin
                iStart = 1'b0;
            end
            @(negedge iclk);
            x = oReady && iValid;
            @(posedge iclk); #1;
            if (x) idx++;
            guard++;
        end
        iValid = 1'b0;
        iStart = 1'b0;
        if (idx < len) check("feed_timeout", idx, len);
        guard = 0;
        while (guard < 5000) begin
            @(negedge iclk);
            if (oDone || oErr) break;
            guard++;
        end
        if (guard >= 5000) check("done_timeout", 0, 1);
        lat = cyc - t0;
        if (valid_pct >= 100) check("latency", lat, 2 * len + 1);
        check("done",     {31'd0, oDone}, {31'd0, !exp_err});
        check("err",      {31'd0, oErr},  {31'd0, exp_err});
        check("checksum", {16'd0, oChecksum}, {16'd0, sum});
        check("busy_end", {31'd0, oBusy}, 32'd0);
        check("all_writes_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        irst_n = 1'b0;
        iStart = 1'b0;
        iBase  = '0;
        iLen   = '0;
        iValid = 1'b0;
        iWord  = '0;
        repeat (3) @(posedge iclk);
        #1;
        check_all_zero("reset");
        irst_n = 1'b1;

        do_load(12'h010, 4, 100, 1, 0);
        do_load(12'h7FE, 3, 100, 0, 0);
        do_load($urandom_range(2047), 2, -1, 0, 0);

        corrupt = 1;
        do_load(12'h010, 4, 100, 0, 0);
        corrupt = 0;

        do_load($urandom_range(2047), 0, 100, 0, 0);
        do_load($urandom_range(2047), 6, 100, 0, 1);

        // Reset after two of four writes, with a third write being presented
        begin
            wr_t e;
            logic [DW-1:0] w0, w1;
            w0 = DW'($urandom);
            w1 = DW'($urandom);
            e.addr = 16'h0100; e.data = w0; exp_q.push_back(e);
            e.addr = 16'h0101; e.data = w1; exp_q.push_back(e);
            @(posedge iclk); #1;
            iStart = 1'b1; iBase = 11'h100; iLen = 12'd4;
            @(posedge iclk); #1;
            iStart = 1'b0; iValid = 1'b1; iWord = w0;
            @(posedge iclk); #1;
            iWord = w1;
            @(posedge iclk); #1;
            iWord = DW'($urandom);
            #2;
            irst_n = 1'b0;
            #1;
            check_all_zero("midreset");
            iValid = 1'b0;
            @(posedge iclk); #1;
            check_all_zero("midreset_held");
            check("midreset_writes", exp_q.size(), 0);
            exp_q.delete();
            irst_n = 1'b1;
        end
        do_load(12'h100, 4, 100, 0, 0);

        for (int k = 0; k < 8; k++)
            do_load($urandom_range(2047), $urandom_range(40, 1), $urandom_range(100, 30), 0, 0);

        do_load($urandom_range(2047), 2048, 100, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
